stk_pipe_mem_tail_ctrl: RTL and testbench
=========================================

Name: stk_pipe_mem_tail_ctrl

Overview:
Controller for the 1024x10 single-port tail-pointer SRAM in the stk pipe. It clears every entry after reset, then shares the single 1RW port between a latency-critical read requester and a write requester. Writes are held in a one-entry write buffer, with forwarding and anti-starvation. It sits between the pipe's tail lookup/update stages and the tail SRAM macro.

Parameters:
W, 10, data width (tail pointer)
N, 1024, SRAM depth; N <= 2**AW
AW, 10, address width
INIT_VALUE, 0, value written to every entry during init
STARVE_MAX, 4, cycles a buffered write may wait before a forced drain; must be >= 1

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
o_init_done  out  1  1 once the init sweep has completed
i_rd_vld  in  1  read request valid
i_rd_addr  in  AW  read address
o_rd_rdy  out  1  read accepted when i_rd_vld & o_rd_rdy
o_rsp_vld  out  1  read response valid
o_rsp_data  out  W  read response data
i_wr_vld  in  1  write request valid
i_wr_addr  in  AW  write address
i_wr_data  in  W  write data
o_wr_rdy  out  1  write accepted when i_wr_vld & o_wr_rdy
o_sram_addr  out  AW  SRAM address
o_sram_din  out  W  SRAM write data
o_sram_ce  out  1  SRAM chip enable
o_sram_oe  out  1  1 = read, 0 = write (only meaningful when ce=1)
i_sram_dout  in  W  SRAM read data, valid the cycle after a read

Behaviour:
- The clock is clk and the reset is arst, which is asynchronous and active-high. All flops reset asynchronously.
- Reset values: state=INIT, init_cnt=0, o_init_done=0, wb_vld=0, starve_cnt=0, o_rsp_vld=0, o_rsp_data=0, fwd_hit_q=0.
- FSM state INIT:
  - Each cycle: ce=1, oe=0, addr=init_cnt, din=INIT_VALUE; init_cnt++.
  - o_rd_rdy=0, o_wr_rdy=0.
  - When init_cnt==N-1 is written, go to RUN. o_init_done=1 from the next cycle.
  - Init takes exactly N cycles.
- FSM state RUN is terminal; only arst leaves it.
- force_drain = wb_vld & (starve_cnt==STARVE_MAX).
- o_rd_rdy = RUN & ~force_drain.
- rd_fire = i_rd_vld & o_rd_rdy.
- Port priority each cycle in RUN:
  1. rd_fire: ce=1, oe=1, addr=i_rd_addr.
  2. Else if wb_vld: drain, with ce=1, oe=0, addr=wb_addr, din=wb_data.
  3. Else ce=0. Addr/din hold their previous values (don't-care).
- o_wr_rdy = RUN & (~wb_vld | drain_this_cycle). The check is combinational on i_rd_vld.
- An accepted write loads wb_addr/wb_data at the clock edge and sets wb_vld. A drain with no new accept clears wb_vld.
- starve_cnt:
  - Cleared on a drain or when wb is empty.
  - Otherwise increments while wb_vld is blocked, saturating at STARVE_MAX.
  - A new write loaded on a drain edge starts at 0.
- Response timing: read accepted in cycle t gives o_rsp_vld=1 in cycle t+1, for one cycle per read. Back-to-back reads stream at 1 per cycle.
- Forwarding:
  - At rd_fire, if wb_vld & wb_addr==i_rd_addr, set fwd_hit_q=1 and capture fwd_data_q=wb_data.
  - o_rsp_data = fwd_hit_q ? fwd_data_q : i_sram_dout.
- Same-cycle read and write accept, same address: the read is ordered first and returns the prior value (SRAM or wb contents). The new write becomes visible to the next read.
- A write can never overwrite wb while wb is undrained. A read and a drain never coincide.
- arst mid-operation:
  - wb contents are discarded and any in-flight response is dropped (o_rsp_vld=0).
  - The full N-entry init sweep reruns.
- i_rd_vld and i_wr_vld are ignored while in INIT.

Test Plan:
- Init sweep: release arst → 1024 consecutive SRAM writes of 0 to addr 0..1023, o_init_done=1 at cycle 1024, rd/wr_rdy=0 throughout; then a read of addr 517 returns 0.
- Write then read: write addr 5 data 0x3A5, next cycle read addr 5 (wb not yet drained) → rsp in the following cycle = 0x3A5 with fwd_hit; after idle drain, read addr 5 from SRAM → 0x3A5.
- Same-cycle conflict: addr 9 holds 0x011; read addr 9 and write addr 9 data 0x2FF in the same cycle → rsp 0x011; the next read of addr 9 → 0x2FF.
- Starvation: buffer a write, then hold i_rd_vld=1 continuously → o_rd_rdy drops after 4 blocked cycles, one SRAM write occurs, and o_rd_rdy returns the next cycle; no read is lost.
- Write backpressure: two writes back-to-back while reads block the port → second write sees o_wr_rdy=0 until the drain cycle, then is accepted; both values are later read correctly.
- Reset mid-run: arst pulsed with wb_vld=1 and a response pending → o_rsp_vld=0 immediately, the full init sweep reruns, and the previously buffered address reads 0 afterwards.

Source files
------------

// File: rtl/stk_pipe_mem_tail_ctrl.sv
// Tail-pointer SRAM controller: init sweep, then 1RW port shared by reads (priority) and a 1-entry write buffer.
// Read data 1 cycle after accept; reads stall only on a forced drain, writes stall while the buffer is full and not draining.
module stk_pipe_mem_tail_ctrl #(
    parameter int W          = 10,
    parameter int N          = 1024,
    parameter int AW         = 10,
    parameter int INIT_VALUE = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          arst,
    output logic          o_init_done,
    input  logic          i_rd_vld,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_rdy,
    output logic          o_rsp_vld,
    output logic [W-1:0]  o_rsp_data,
    input  logic          i_wr_vld,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    output logic          o_wr_rdy,
    output logic [AW-1:0] o_sram_addr,
    output logic [W-1:0]  o_sram_din,
    output logic          o_sram_ce,
    output logic          o_sram_oe,
    input  logic [W-1:0]  i_sram_dout
);
    localparam int            SW     = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] LAST   = AW'(N - 1);
    localparam logic [SW-1:0] SMAX   = SW'(STARVE_MAX);
    localparam logic [W-1:0]  INIT_V = W'(INIT_VALUE);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    logic [AW-1:0] init_cnt;
    logic          wb_vld;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic [SW-1:0] starve_cnt;
    logic          fwd_hit_q;
    logic [W-1:0]  fwd_data_q;
    logic [AW-1:0] addr_q;
    logic [W-1:0]  din_q;

    logic run, force_drain, rd_fire, drain, wr_fire;

    assign run         = (state == S_RUN);
    assign force_drain = wb_vld & (starve_cnt == SMAX);
    assign o_rd_rdy    = run & ~force_drain;
    assign rd_fire     = i_rd_vld & o_rd_rdy;
    assign drain       = run & wb_vld & ~rd_fire;
    assign o_wr_rdy    = run & (~wb_vld | drain);
    assign wr_fire     = i_wr_vld & o_wr_rdy;

    // Response mux is zeroed between responses so the idle bus is quiet.
    assign o_rsp_data = o_rsp_vld ? (fwd_hit_q ? fwd_data_q : i_sram_dout) : '0;

    always_comb begin
        o_sram_ce   = 1'b0;
        o_sram_oe   = 1'b0;
        o_sram_addr = addr_q;
        o_sram_din  = din_q;
        if (!run) begin
            o_sram_ce   = 1'b1;
            o_sram_addr = init_cnt;
            o_sram_din  = INIT_V;
        end else if (rd_fire) begin
            o_sram_ce   = 1'b1;
            o_sram_oe   = 1'b1;
            o_sram_addr = i_rd_addr;
        end else if (drain) begin
            o_sram_ce   = 1'b1;
            o_sram_addr = wb_addr;
            o_sram_din  = wb_data;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_INIT;
            init_cnt    <= '0;
            o_init_done <= 1'b0;
            wb_vld      <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            starve_cnt  <= '0;
            o_rsp_vld   <= 1'b0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            addr_q <= o_sram_addr;
            din_q  <= o_sram_din;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + AW'(1);
                    if (init_cnt == LAST) begin
                        state       <= S_RUN;
                        o_init_done <= 1'b1;
                    end
                end
                default: begin
                    o_rsp_vld <= rd_fire;
                    // Forward compares against the buffer as it stood before this edge's write accept.
                    fwd_hit_q <= rd_fire & wb_vld & (wb_addr == i_rd_addr);
                    if (rd_fire)
                        fwd_data_q <= wb_data;
                    if (wr_fire) begin
                        wb_vld     <= 1'b1;
                        wb_addr    <= i_wr_addr;
                        wb_data    <= i_wr_data;
                        starve_cnt <= '0;
                    end else if (drain) begin
                        wb_vld     <= 1'b0;
                        starve_cnt <= '0;
                    end else if (wb_vld) begin
                        if (starve_cnt != SMAX)
                            starve_cnt <= starve_cnt + SW'(1);
                    end else begin
                        starve_cnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stk_pipe_mem_tail_ctrl.sv
module tb_stk_pipe_mem_tail_ctrl;
    logic       clk = 1'b0;
    logic       arst;
    logic       o_init_done;
    logic       i_rd_vld;
    logic [9:0] i_rd_addr;
    logic       o_rd_rdy;
    logic       o_rsp_vld;
    logic [9:0] o_rsp_data;
    logic       i_wr_vld;
    logic [9:0] i_wr_addr;
    logic [9:0] i_wr_data;
    logic       o_wr_rdy;
    logic [9:0] o_sram_addr;
    logic [9:0] o_sram_din;
    logic       o_sram_ce;
    logic       o_sram_oe;
    logic [9:0] i_sram_dout;

    logic [9:0] mem [0:1023];
    logic [9:0] sb [$];
    int checks = 0;
    int failures = 0;

    stk_pipe_mem_tail_ctrl dut (
        .clk(clk), .arst(arst), .o_init_done(o_init_done),
        .i_rd_vld(i_rd_vld), .i_rd_addr(i_rd_addr), .o_rd_rdy(o_rd_rdy),
        .o_rsp_vld(o_rsp_vld), .o_rsp_data(o_rsp_data),
        .i_wr_vld(i_wr_vld), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy),
        .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din), .o_sram_ce(o_sram_ce),
        .o_sram_oe(o_sram_oe), .i_sram_dout(i_sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural 1RW SRAM: read data appears the cycle after the read.
    always @(posedge clk) begin
        if (o_sram_ce) begin
            if (o_sram_oe) i_sram_dout <= mem[o_sram_addr];
            else           mem[o_sram_addr] <= o_sram_din;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!arst && o_rsp_vld) begin
                if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_data", int'(o_rsp_data), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        i_rd_vld = 1'b0;
        i_wr_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic init_sweep();
        int errs = 0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (!(o_sram_ce && !o_sram_oe && o_sram_addr == 10'(i) && o_sram_din == 10'd0 &&
                  !o_rd_rdy && !o_wr_rdy && !o_init_done)) errs++;
            @(negedge clk);
        end
        chk("init_sweep_errs", errs, 0);
        #1;
        chk("init_done", int'(o_init_done), 1);
        idle(0);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [9:0] e);
        bit done = 0;
        i_rd_vld = 1'b1;
        i_rd_addr = a;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (o_rd_rdy) begin
                sb.push_back(e);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("rd_timeout", 1, 0);
        i_rd_vld = 1'b0;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [9:0] d);
        bit done = 0;
        i_wr_vld = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (o_wr_rdy) done = 1;
            @(negedge clk);
        end
        if (!done) chk("wr_timeout", 1, 0);
        i_wr_vld = 1'b0;
    endtask

    initial begin
        logic [7:0]  rdy8;
        logic [11:0] rdy12;
        logic [5:0]  wrb;
        int          wr_cnt;
        int          drain_addr;
        int          ws;

        arst = 1'b1;
        i_rd_vld = 0; i_rd_addr = 0; i_wr_vld = 0; i_wr_addr = 0; i_wr_data = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_init_done", int'(o_init_done), 0);
        chk("rst_rsp_vld", int'(o_rsp_vld), 0);
        chk("rst_rsp_data", int'(o_rsp_data), 0);
        chk("rst_rd_rdy", int'(o_rd_rdy), 0);
        @(negedge clk);
        arst = 1'b0;
        i_rd_vld = 1'b1;
        i_wr_vld = 1'b1;
        init_sweep();
        do_read(10'd517, 10'h000);

        // Forwarded read of a still-buffered write, then the drained copy.
        do_write(10'd5, 10'h3A5);
        do_read(10'd5, 10'h3A5);
        idle(2);
        do_read(10'd5, 10'h3A5);

        // Same-cycle read/write to one address: read sees the older value.
        idle(2);
        do_write(10'd9, 10'h011);
        idle(2);
        i_rd_vld = 1'b1; i_rd_addr = 10'd9;
        i_wr_vld = 1'b1; i_wr_addr = 10'd9; i_wr_data = 10'h2FF;
        #1;
        chk("conflict_rd_rdy", int'(o_rd_rdy), 1);
        chk("conflict_wr_rdy", int'(o_wr_rdy), 1);
        if (o_rd_rdy) sb.push_back(10'h011);
        @(negedge clk);
        idle(0);
        do_read(10'd9, 10'h2FF);
        idle(2);
        do_read(10'd9, 10'h2FF);

        // Starvation: continuous reads hold off a buffered write for four cycles.
        idle(3);
        do_write(10'd20, 10'h0AB);
        i_rd_vld = 1'b1; i_rd_addr = 10'd30;
        rdy8 = '0; wr_cnt = 0; drain_addr = -1;
        for (int k = 0; k < 8; k++) begin
            #1;
            rdy8[k] = o_rd_rdy;
            if (o_sram_ce && !o_sram_oe) begin
                wr_cnt++;
                drain_addr = int'(o_sram_addr);
            end
            if (o_rd_rdy) sb.push_back(10'h000);
            @(negedge clk);
        end
        idle(0);
        chk("starve_rd_rdy_pattern", int'(rdy8), 'hEF);
        chk("starve_drain_count", wr_cnt, 1);
        chk("starve_drain_addr", drain_addr, 20);
        do_read(10'd20, 10'h0AB);

        // Write backpressure while reads occupy the port.
        idle(3);
        i_rd_vld = 1'b1; i_rd_addr = 10'd31;
        ws = 0; wrb = '0; rdy12 = '0;
        for (int k = 0; k < 12; k++) begin
            if (ws == 0) begin
                i_wr_vld = 1'b1; i_wr_addr = 10'd40; i_wr_data = 10'h111;
            end else if (ws == 1) begin
                i_wr_vld = 1'b1; i_wr_addr = 10'd41; i_wr_data = 10'h222;
            end else begin
                i_wr_vld = 1'b0;
            end
            #1;
            rdy12[k] = o_rd_rdy;
            if (o_rd_rdy) sb.push_back(10'h000);
            if (ws < 2) begin
                if (k < 6) wrb[k] = o_wr_rdy;
                if (o_wr_rdy) ws++;
            end
            @(negedge clk);
        end
        idle(1);
        chk("bp_wr_rdy_pattern", int'(wrb), 'h21);
        chk("bp_rd_rdy_pattern", int'(rdy12), 'hBDF);
        chk("bp_writes_accepted", ws, 2);
        do_read(10'd40, 10'h111);
        do_read(10'd41, 10'h222);

        // Reset with a buffered write and a response in flight.
        idle(2);
        do_write(10'd50, 10'h155);
        i_rd_vld = 1'b1; i_rd_addr = 10'd50;
        #1;
        chk("rst_mid_rd_rdy", int'(o_rd_rdy), 1);
        @(posedge clk);
        #1;
        arst = 1'b1;
        i_rd_vld = 1'b0;
        #1;
        chk("rst_mid_rsp_vld", int'(o_rsp_vld), 0);
        chk("rst_mid_init_done", int'(o_init_done), 0);
        @(negedge clk);
        arst = 1'b0;
        init_sweep();
        do_read(10'd50, 10'h000);

        idle(4);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
